// File: rtl/nr_frame_pkg.sv
// rtl/nr_frame_pkg.sv - NR frame numbering constants, tuser layout and gate state type
package nr_frame_pkg;

  localparam int SFN_MAX             = 1023;
  localparam int SUBFRAMES_PER_FRAME = 20;
  localparam int SYM_PER_SF          = 14;

  localparam int SFN_WIDTH = $clog2(SFN_MAX + 1);
  localparam int SF_WIDTH  = 5;
  localparam int SYM_WIDTH = 4;

  // tuser layout, LSB first: pbch_flag, blk_exp, symbol, subframe, sfn
  localparam int PBCH_OFS    = 0;
  localparam int BLK_EXP_OFS = 1;

  typedef struct packed {
    logic [SFN_WIDTH-1:0] sfn;
    logic [SF_WIDTH-1:0]  subframe;
    logic [SYM_WIDTH-1:0] symbol;
  } frame_pos_t;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_SOS,
    PASS,
    DROP
  } gate_state_t;

  function automatic frame_pos_t unpack_pos(input logic [63:0] tuser, input int blk_exp_len);
    logic [63:0] sh;
    frame_pos_t  pos;
    sh           = tuser >> (BLK_EXP_OFS + blk_exp_len);
    pos.symbol   = sh[SYM_WIDTH-1:0];
    sh           = sh >> SYM_WIDTH;
    pos.subframe = sh[SF_WIDTH-1:0];
    sh           = sh >> SF_WIDTH;
    pos.sfn      = sh[SFN_WIDTH-1:0];
    return pos;
  endfunction

endpackage

// File: rtl/bwp_sched_decision.sv
// rtl/bwp_sched_decision.sv - combinational forward/drop decision for one symbol
module bwp_sched_decision
  import nr_frame_pkg::*;
(
  input  logic                           enable_i,
  input  logic [SYM_PER_SF-1:0]          sym_mask_i,
  input  logic [SUBFRAMES_PER_FRAME-1:0] sf_mask_i,
  input  logic [3:0]                     sfn_period_log2_i,
  input  logic [SFN_WIDTH-1:0]           sfn_i,
  input  logic [SF_WIDTH-1:0]            subframe_i,
  input  logic [SYM_WIDTH-1:0]           symbol_i,
  output logic                           decision_o
);

  logic [15:0] period_mask;
  logic        sym_ok;
  logic        sf_ok;
  logic        sfn_ok;

  always_comb begin
    period_mask = ~(16'hFFFF << sfn_period_log2_i);
    // range checks first so out-of-range fields never index the masks
    sym_ok      = (32'(symbol_i) < SYM_PER_SF) && sym_mask_i[symbol_i];
    sf_ok       = (32'(subframe_i) < SUBFRAMES_PER_FRAME) && sf_mask_i[subframe_i];
    sfn_ok      = (16'(sfn_i) & period_mask) == 16'd0;
    decision_o  = enable_i && sym_ok && sf_ok && sfn_ok;
  end

endmodule

// File: rtl/bwp_symbol_gate.sv
// rtl/bwp_symbol_gate.sv - per-symbol schedule gate with length check after BWP extraction
module bwp_symbol_gate
  import nr_frame_pkg::*;
#(
  parameter  int IN_DW       = 16,
  parameter  int BLK_EXP_LEN = 8,
  parameter  int BWP_LEN     = 240,
  localparam int USER_WIDTH  = SFN_WIDTH + SF_WIDTH + SYM_WIDTH + BLK_EXP_LEN + 1,
  localparam int CNT_WIDTH   = $clog2(BWP_LEN + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [IN_DW-1:0]      s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_in_tuser,
  input  logic                  s_axis_in_tlast,
  input  logic                  s_axis_in_tvalid,
  input  logic                  enable_i,
  input  logic [13:0]           cfg_sym_mask_i,
  input  logic [19:0]           cfg_sf_mask_i,
  input  logic [3:0]            cfg_sfn_period_log2_i,
  output logic [IN_DW-1:0]      m_axis_out_tdata,
  output logic [USER_WIDTH-1:0] m_axis_out_tuser,
  output logic                  m_axis_out_tlast,
  output logic                  m_axis_out_tvalid,
  output logic                  synced_o,
  output logic                  err_len_o,
  output logic [15:0]           drop_cnt_o
);

  gate_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                  synced_q, synced_d;
  logic                  err_q, err_d;
  logic [15:0]           drop_q, drop_d;
  logic                  sh_en_q, sh_en_d;
  logic [13:0]           sh_sym_q, sh_sym_d;
  logic [19:0]           sh_sf_q, sh_sf_d;
  logic [3:0]            sh_per_q, sh_per_d;
  logic [IN_DW-1:0]      out_data_q, out_data_d;
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  decision;
  logic                  fwd;
  frame_pos_t            pos;

  assign pos = unpack_pos(64'(s_axis_in_tuser), BLK_EXP_LEN);

  // Shadow config is captured only on the first beat of a symbol
  always_comb begin
    sh_en_d  = sh_en_q;
    sh_sym_d = sh_sym_q;
    sh_sf_d  = sh_sf_q;
    sh_per_d = sh_per_q;
    if (s_axis_in_tvalid && state_q == WAIT_SOS) begin
      sh_en_d  = enable_i;
      sh_sym_d = cfg_sym_mask_i;
      sh_sf_d  = cfg_sf_mask_i;
      sh_per_d = cfg_sfn_period_log2_i;
    end
  end

  bwp_sched_decision u_decision (
    .enable_i          (sh_en_d),
    .sym_mask_i        (sh_sym_d),
    .sf_mask_i         (sh_sf_d),
    .sfn_period_log2_i (sh_per_d),
    .sfn_i             (pos.sfn),
    .subframe_i        (pos.subframe),
    .symbol_i          (pos.symbol),
    .decision_o        (decision)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    synced_d    = synced_q;
    err_d       = 1'b0;
    drop_d      = drop_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    out_valid_d = 1'b0;
    fwd         = 1'b0;
    cnt_inc     = (state_q == WAIT_SOS) ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);

    if (s_axis_in_tvalid) begin
      out_data_d = s_axis_in_tdata;
      out_user_d = s_axis_in_tuser;
      out_last_d = s_axis_in_tlast;

      case (state_q)
        SYNC: begin
          if (s_axis_in_tlast) begin
            state_d  = WAIT_SOS;
            synced_d = 1'b1;
            cnt_d    = '0;
          end
        end
        WAIT_SOS: begin
          if (decision) begin
            fwd     = 1'b1;
            state_d = PASS;
          end else begin
            state_d = DROP;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
        PASS:    fwd = 1'b1;
        default: fwd = 1'b0;
      endcase

      // Length check overrides the next state chosen above
      if (state_q != SYNC) begin
        if (s_axis_in_tlast) begin
          err_d   = (cnt_inc != CNT_WIDTH'(BWP_LEN));
          state_d = WAIT_SOS;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_WIDTH'(BWP_LEN)) begin
          err_d    = 1'b1;
          state_d  = SYNC;
          synced_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      out_valid_d = fwd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      synced_q    <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
      sh_en_q     <= 1'b0;
      sh_sym_q    <= '0;
      sh_sf_q     <= '0;
      sh_per_q    <= '0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      synced_q    <= synced_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      sh_en_q     <= sh_en_d;
      sh_sym_q    <= sh_sym_d;
      sh_sf_q     <= sh_sf_d;
      sh_per_q    <= sh_per_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tuser  = out_user_q;
  assign m_axis_out_tlast  = out_last_q;
  assign m_axis_out_tvalid = out_valid_q;
  assign synced_o          = synced_q;
  assign err_len_o         = err_q;
  assign drop_cnt_o        = drop_q;

endmodule

// File: doc/bwp_symbol_gate.md
Name: bwp_symbol_gate

Overview:
- Scheduler placed directly after the bandwidth-part extractor on the frequency-domain path.
- Decides per OFDM symbol whether the extracted 240-subcarrier block is forwarded to downstream channel estimators and decoders, using a runtime symbol, subframe and SFN schedule.
- Enforces whole-symbol granularity and checks symbol length.
- Reports drops and framing errors to the control plane.

Parameters:
- IN_DW, 16, sample width (I/Q packed).
- BLK_EXP_LEN, 8, FFT block-exponent field width in tuser.
- BWP_LEN, 240, expected subcarriers per symbol (tlast on the last one).
- localparam SFN_WIDTH = 10, SF_WIDTH = 5, SYM_WIDTH = 4.
- localparam USER_WIDTH = SFN_WIDTH + SF_WIDTH + SYM_WIDTH + BLK_EXP_LEN + 1 = 28.
- localparam CNT_WIDTH = $clog2(BWP_LEN + 1).

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  synchronous active-low reset
- s_axis_in_tdata  in  IN_DW  subcarrier sample
- s_axis_in_tuser  in  USER_WIDTH  {sfn, subframe, symbol, blk_exp, pbch_flag}, MSB→LSB
- s_axis_in_tlast  in  1  last subcarrier of symbol
- s_axis_in_tvalid  in  1  sample valid (no backpressure)
- enable_i  in  1  gate enable
- cfg_sym_mask_i  in  14  bit n=1 forwards symbol n
- cfg_sf_mask_i  in  20  bit n=1 forwards subframe n
- cfg_sfn_period_log2_i  in  4  forward only when sfn[period-1:0]==0 (0 = every frame)
- m_axis_out_tdata  out  IN_DW  forwarded sample
- m_axis_out_tuser  out  USER_WIDTH  forwarded tuser, unchanged
- m_axis_out_tlast  out  1  forwarded tlast
- m_axis_out_tvalid  out  1  forwarded valid
- synced_o  out  1  high once symbol boundaries are locked
- err_len_o  out  1  one-cycle pulse on symbol length error
- drop_cnt_o  out  16  symbols dropped by schedule, saturating

Behaviour:
- Reset: every output 0, state SYNC, shadow config 0, sample counter 0, drop_cnt_o 0.
- Clocking: one clock domain; all state updates only on cycles with s_axis_in_tvalid=1, except the error pulse clear.
- FSM states:
  - SYNC: output suppressed. On a valid beat with tlast=1 → WAIT_SOS, synced_o←1.
  - WAIT_SOS: on the first valid beat, latch shadow config from the cfg_* inputs and enable_i, then evaluate the decision on that beat's tuser.
    - decision = enable && sym_mask[symbol] && sf_mask[subframe] && ((sfn & ((1<<period)-1))==0).
    - symbol ≥ 14 or subframe ≥ 20 gives decision = 0.
    - decision=1 → PASS; decision=0 → DROP and drop_cnt_o+1, saturating at 0xFFFF.
    - If that first beat also has tlast, the length check applies and the FSM stays in WAIT_SOS.
  - PASS: forward each beat. On tlast → WAIT_SOS.
  - DROP: discard beats. On tlast → WAIT_SOS.
- Config changes and enable_i changes take effect only at the next symbol start; a symbol in progress is never truncated.
- Output latency: exactly 1 cycle, registered. m_axis_out_tvalid = registered (tvalid && forwarding), where forwarding includes the decision beat itself. tdata, tuser and tlast are registered on every valid beat.
- Length check: the sample counter counts valid beats within a symbol.
  - tlast with count+1 ≠ BWP_LEN → err_len_o pulse; the symbol still ends normally.
  - count reaches BWP_LEN with no tlast → err_len_o pulse, state → SYNC, synced_o←0, and the remaining beats are suppressed until the next tlast.
- err_len_o is high for exactly one cycle per error.
- Reset asserted mid-symbol: immediate return to reset state; no output until the next tlast resyncs.
- tvalid gaps inside a symbol: counter and state hold; no effect.

Decomposition:
- Shared package nr_frame_pkg holds:
  - SFN_MAX, SUBFRAMES_PER_FRAME, SYM_PER_SF
  - SFN_WIDTH, SF_WIDTH, SYM_WIDTH
  - tuser field offsets, and a function to unpack sfn/subframe/symbol from tuser
  - typedef enum gate_state_t {SYNC, WAIT_SOS, PASS, DROP}
- One sub-module, bwp_sched_decision: purely combinational decision evaluation from the shadow config plus tuser fields. It is testable standalone.

Test Plan:
- Reset, then 3 symbols of 240 beats with all masks 1 and period 0 → first symbol dropped silently (SYNC), next 2 forwarded; 480 output beats, tlast on output beats 240 and 480, latency 1.
- sym_mask=0x0018, sf_mask=0x1, subframe 0, symbols 0..13 → only symbols 3 and 4 forwarded; drop_cnt_o=12.
- period_log2=2, SFN 0..7, all symbol/subframe masks set → symbols forwarded only for SFN 0 and 4.
- enable_i drops at beat 100 of a forwarded symbol → remaining 140 beats still forwarded; the next symbol is dropped.
- Symbol with tlast at beat 200 → err_len_o single pulse, state WAIT_SOS, next symbol forwarded. Symbol of 260 beats without tlast → err_len_o at beat 240, synced_o=0, resync on the next tlast.
- Reset pulse at beat 50 of a forwarded symbol → outputs 0 next cycle, drop_cnt_o=0, no output until a tlast is seen.
